// File: rtl/rob.sv
// rob: in-order reorder buffer with combinational tail index, writeback marking and valid/ready commit
module rob #(
    parameter int DEPTH = 64,
    parameter int IDX_W = 6,
    parameter int UOP_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [UOP_W-1:0] alloc_uop,
    output logic             alloc_ready,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic             wb_exc,
    output logic             commit_valid,
    output logic [UOP_W-1:0] commit_uop,
    output logic [IDX_W-1:0] commit_idx,
    output logic             commit_exc,
    input  logic             commit_ready,
    input  logic             flush,
    output logic [IDX_W:0]   count,
    output logic             empty
);
    logic [DEPTH-1:0] valid, done, exc;
    logic [UOP_W-1:0] uop [DEPTH];
    logic [IDX_W:0]   head, tail;
    logic [IDX_W-1:0] hd, tl;
    logic             full, alloc_fire, wb_fire, commit_fire;

    assign hd = head[IDX_W-1:0];
    assign tl = tail[IDX_W-1:0];
    assign full = (head[IDX_W] != tail[IDX_W]) && (hd == tl);
    assign empty = head == tail;
    // Pointer difference including the wrap bit yields 0..DEPTH directly.
    assign count = tail - head;
    assign alloc_ready = !full && !flush;
    assign alloc_idx = tl;
    assign alloc_fire = alloc_valid && alloc_ready;
    // A writeback colliding with a same-cycle allocation loses to the new entry.
    assign wb_fire = wb_valid && valid[wb_idx] && !(alloc_fire && wb_idx == tl);
    assign commit_valid = valid[hd] && done[hd] && !flush;
    assign commit_fire = commit_valid && commit_ready;
    assign commit_uop = uop[hd];
    assign commit_idx = hd;
    assign commit_exc = exc[hd];

    // Entry status bits and pointers; flush overrides every other update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
            done  <= '0;
            exc   <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            valid <= '0;
        end else begin
            if (alloc_fire) begin
                valid[tl] <= 1'b1;
                done[tl]  <= 1'b0;
                exc[tl]   <= 1'b0;
                tail      <= tail + 1'b1;
            end
            if (wb_fire) begin
                done[wb_idx] <= 1'b1;
                exc[wb_idx]  <= wb_exc;
            end
            if (commit_fire) begin
                valid[hd] <= 1'b0;
                head      <= head + 1'b1;
            end
        end
    end

    // Uop payload needs no reset; the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (alloc_fire) uop[tl] <= alloc_uop;
    end
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed scoreboard bench for the reorder buffer
module tb_rob;
    localparam int IDX_W = 6;
    localparam int UOP_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             alloc_valid = 1'b0;
    logic [UOP_W-1:0] alloc_uop = '0;
    logic             alloc_ready;
    logic [IDX_W-1:0] alloc_idx;
    logic             wb_valid = 1'b0;
    logic [IDX_W-1:0] wb_idx = '0;
    logic             wb_exc = 1'b0;
    logic             commit_valid;
    logic [UOP_W-1:0] commit_uop;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_exc;
    logic             commit_ready = 1'b0;
    logic             flush = 1'b0;
    logic [IDX_W:0]   count;
    logic             empty;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [UOP_W-1:0] uop;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    rob #(.DEPTH(64), .IDX_W(IDX_W), .UOP_W(UOP_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_uop(alloc_uop), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
        .commit_valid(commit_valid), .commit_uop(commit_uop), .commit_idx(commit_idx),
        .commit_exc(commit_exc), .commit_ready(commit_ready),
        .flush(flush), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; records fires then advances one cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (!flush && alloc_valid && alloc_ready) sb.push_back(exp_t'{alloc_idx, alloc_uop});
        if (commit_valid && commit_ready) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("commit_idx", 64'(commit_idx), 64'(e.idx));
                chk("commit_uop", 64'(commit_uop), 64'(e.uop));
            end
        end
        if (flush) sb.delete();
        @(negedge clk);
    endtask

    task automatic do_flush();
        alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        chk("rst_alloc_idx", 64'(alloc_idx), 64'(0));
        chk("rst_commit_valid", 64'(commit_valid), 64'(0));
        chk("rst_commit_idx", 64'(commit_idx), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 64 back-to-back allocations fill the buffer
        for (int i = 0; i < 64; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            chk("fill_idx", 64'(alloc_idx), 64'(i));
            tick();
        end
        chk("full_ready", 64'(alloc_ready), 64'(0));
        chk("full_count", 64'(count), 64'(64));
        alloc_uop = $urandom;
        tick();
        chk("ignored_count", 64'(count), 64'(64));
        chk("ignored_idx", 64'(alloc_idx), 64'(0));

        // Full buffer: commit fires, simultaneous alloc does not
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_idx = 6'd0;
        tick();
        wb_valid = 1'b0; commit_ready = 1'b1; alloc_valid = 1'b1; alloc_uop = $urandom;
        #1;
        chk("full_commit_valid", 64'(commit_valid), 64'(1));
        chk("full_alloc_blocked", 64'(alloc_ready), 64'(0));
        tick();
        alloc_valid = 1'b0; commit_ready = 1'b0;
        chk("after_commit_count", 64'(count), 64'(63));
        chk("after_commit_ready", 64'(alloc_ready), 64'(1));
        do_flush();

        // Out-of-order writeback, in-order commit
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            tick();
        end
        alloc_valid = 1'b0; commit_ready = 1'b1;
        wb_valid = 1'b1; wb_idx = 6'd2; tick();
        chk("ooo_no_commit_a", 64'(commit_valid), 64'(0));
        wb_idx = 6'd1; tick();
        chk("ooo_no_commit_b", 64'(commit_valid), 64'(0));
        wb_idx = 6'd0; #1;
        chk("ooo_wb_not_visible", 64'(commit_valid), 64'(0));
        tick();
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("ooo_commit_valid", 64'(commit_valid), 64'(1));
            chk("ooo_commit_order", 64'(commit_idx), 64'(i));
            tick();
        end
        chk("ooo_empty", 64'(empty), 64'(1));
        do_flush();

        // Fill to 60, drain, then allocate across the index wrap
        for (int i = 0; i < 60; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            tick();
        end
        alloc_valid = 1'b0; wb_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            wb_idx = 6'(i);
            tick();
        end
        wb_valid = 1'b0; commit_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk("drain_idx", 64'(commit_idx), 64'(i));
            tick();
        end
        commit_ready = 1'b0;
        chk("drain_count", 64'(count), 64'(0));
        for (int i = 0; i < 10; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            chk("wrap_idx", 64'(alloc_idx), 64'((60 + i) % 64));
            tick();
            chk("wrap_not_empty", 64'(empty), 64'(0));
        end
        alloc_valid = 1'b0;
        chk("wrap_count", 64'(count), 64'(10));
        chk("wrap_not_full", 64'(alloc_ready), 64'(1));
        do_flush();

        // Flush with 5 live entries beats alloc, writeback and commit
        for (int i = 0; i < 5; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            tick();
        end
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_idx = 6'd0;
        tick();
        flush = 1'b1; alloc_valid = 1'b1; wb_idx = 6'd1; commit_ready = 1'b1;
        #1;
        chk("flush_alloc_ready", 64'(alloc_ready), 64'(0));
        chk("flush_commit_valid", 64'(commit_valid), 64'(0));
        tick();
        flush = 1'b0; alloc_valid = 1'b0; wb_valid = 1'b0; commit_ready = 1'b0;
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_alloc_idx", 64'(alloc_idx), 64'(0));
        chk("flush_empty", 64'(empty), 64'(1));

        // Exception writeback on head index 7
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            tick();
        end
        alloc_valid = 1'b0; commit_ready = 1'b1; wb_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wb_idx = 6'(i);
            tick();
        end
        wb_valid = 1'b0;
        tick();
        commit_ready = 1'b0; wb_valid = 1'b1; wb_idx = 6'd7; wb_exc = 1'b1;
        #1;
        chk("exc_not_yet", 64'(commit_valid), 64'(0));
        tick();
        wb_valid = 1'b0; wb_exc = 1'b0;
        chk("exc_commit_valid", 64'(commit_valid), 64'(1));
        chk("exc_commit_idx", 64'(commit_idx), 64'(7));
        chk("exc_commit_exc", 64'(commit_exc), 64'(1));
        commit_ready = 1'b1;
        tick();
        commit_ready = 1'b0;
        chk("exc_empty", 64'(empty), 64'(1));

        // Asynchronous reset mid-run drops live entries
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1; alloc_uop = $urandom;
            tick();
        end
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_idx = 6'd8;
        tick();
        wb_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'(3));
        chk("pre_rst_commit_valid", 64'(commit_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(count), 64'(0));
        chk("midrst_commit_valid", 64'(commit_valid), 64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_empty", 64'(empty), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
